// File: rtl/hv_adc_ctrl_pkg.sv
// Shared HV ADC definitions: data width, scheduler FSM states and the minimum
// round period.
package hv_adc_ctrl_pkg;

  localparam int unsigned HV_ADC_DW     = 10;
  localparam int unsigned HV_MIN_PERIOD = 16;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StNext
  } hv_adc_state_e;

  // Requested periods shorter than the minimum are stretched up to it.
  function automatic logic [15:0] hv_eff_period(input logic [15:0] period);
    return (period < 16'(HV_MIN_PERIOD)) ? 16'(HV_MIN_PERIOD) : period;
  endfunction

endpackage

// File: rtl/hv_adc_rdy_sync.sv
// Two-flop synchronizer for the asynchronous analog ready flag, followed by a
// rising-edge detector on the synchronized value.
module hv_adc_rdy_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rdy,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_rdy;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/hv_adc_ctrl.sv
// Two-channel HV ADC scheduler: periodic rounds, start pulse, ready wait with
// timeout, result capture and sticky error flags.
module hv_adc_ctrl
  import hv_adc_ctrl_pkg::*;
#(
  parameter int unsigned ADC_DW    = HV_ADC_DW,
  parameter int unsigned START_CYC = 2,
  parameter int unsigned TMO_CYC   = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_adc_en,
  input  logic [1:0]        i_ch_en,
  input  logic [15:0]       i_smp_period,
  input  logic              i_err_clr,
  input  logic              i_ang_dgt_adc_rdy,
  input  logic [ADC_DW-1:0] i_ang_dgt_adc_data,
  output logic              o_dgt_ang_adc_start,
  output logic              o_dgt_ang_adc_sel,
  output logic              o_smp_vld,
  output logic              o_smp_ch,
  output logic [ADC_DW-1:0] o_smp_data,
  output logic [1:0]        o_tmo_err,
  output logic              o_ovr_err,
  output logic              o_busy
);

  localparam logic [15:0] StartLast = 16'(START_CYC - 1);
  localparam logic [15:0] TmoLast   = 16'(TMO_CYC - 1);

  hv_adc_state_e     r_state, w_state_d;
  logic [15:0]       r_per_cnt;
  logic [15:0]       r_cyc, w_cyc_d;
  logic              r_sel, w_sel_d;
  logic              r_pend, w_pend_d;
  logic              r_smp_vld, w_vld_d;
  logic              r_smp_ch;
  logic [ADC_DW-1:0] r_smp_data;
  logic [1:0]        r_tmo_err, w_tmo_set;
  logic              r_ovr_err;
  logic              w_cap;
  logic              w_rise;
  logic              w_tick;
  logic              w_ovr_set;
  logic [15:0]       w_per;

  hv_adc_rdy_sync u_rdy_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_rdy  (i_ang_dgt_adc_rdy),
    .o_rise (w_rise)
  );

  assign w_per     = hv_eff_period(i_smp_period);
  assign w_tick    = i_adc_en && (r_per_cnt == 16'd0);
  assign w_ovr_set = w_tick && (r_state != StIdle);

  // '>=' keeps the count in range if the period shrinks mid-count.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_adc_en) begin
      r_per_cnt <= 16'd0;
    end else if (r_per_cnt >= w_per - 16'd1) begin
      r_per_cnt <= 16'd0;
    end else begin
      r_per_cnt <= r_per_cnt + 16'd1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cyc_d   = r_cyc;
    w_sel_d   = r_sel;
    w_pend_d  = r_pend;
    w_vld_d   = 1'b0;
    w_cap     = 1'b0;
    w_tmo_set = 2'b00;
    unique case (r_state)
      StIdle: begin
        if (w_tick && (i_ch_en != 2'b00)) begin
          w_sel_d   = ~i_ch_en[0];
          w_pend_d  = &i_ch_en;
          w_cyc_d   = 16'd0;
          w_state_d = StStart;
        end
      end
      StStart: begin
        if (r_cyc == StartLast) begin
          w_cyc_d   = 16'd0;
          w_state_d = StWait;
        end else begin
          w_cyc_d = r_cyc + 16'd1;
        end
      end
      StWait: begin
        if (w_rise) begin
          w_cap     = 1'b1;
          w_vld_d   = 1'b1;
          w_state_d = StNext;
        end else if (r_cyc == TmoLast) begin
          w_tmo_set[r_sel] = 1'b1;
          w_state_d        = StNext;
        end else begin
          w_cyc_d = r_cyc + 16'd1;
        end
      end
      StNext: begin
        if (r_pend) begin
          w_sel_d   = 1'b1;
          w_pend_d  = 1'b0;
          w_cyc_d   = 16'd0;
          w_state_d = StStart;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Dropping the enable aborts the round with no strobe and no timeout.
    if (!i_adc_en) begin
      w_state_d = StIdle;
      w_vld_d   = 1'b0;
      w_cap     = 1'b0;
      w_tmo_set = 2'b00;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_cyc      <= 16'd0;
      r_sel      <= 1'b0;
      r_pend     <= 1'b0;
      r_smp_vld  <= 1'b0;
      r_smp_ch   <= 1'b0;
      r_smp_data <= '0;
      r_tmo_err  <= 2'b00;
      r_ovr_err  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cyc     <= w_cyc_d;
      r_sel     <= w_sel_d;
      r_pend    <= w_pend_d;
      r_smp_vld <= w_vld_d;
      if (w_cap) begin
        r_smp_ch   <= r_sel;
        r_smp_data <= i_ang_dgt_adc_data;
      end
      // A flag being set in the same cycle as a clear stays set.
      r_tmo_err <= (i_err_clr ? 2'b00 : r_tmo_err) | w_tmo_set;
      r_ovr_err <= (i_err_clr ? 1'b0 : r_ovr_err) | w_ovr_set;
    end
  end

  assign o_dgt_ang_adc_start = (r_state == StStart);
  assign o_dgt_ang_adc_sel   = r_sel;
  assign o_smp_vld           = r_smp_vld;
  assign o_smp_ch            = r_smp_ch;
  assign o_smp_data          = r_smp_data;
  assign o_tmo_err           = r_tmo_err;
  assign o_ovr_err           = r_ovr_err;
  assign o_busy              = (r_state != StIdle);

endmodule

// File: tb/tb_hv_adc_ctrl.sv
// Scoreboard bench for hv_adc_ctrl: a behavioural analog front end answers each
// start pulse, and a monitor matches every result strobe against expectations.
module tb_hv_adc_ctrl;

  localparam int DW        = 10;
  localparam int START_CYC = 2;
  localparam int TMO_CYC   = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    ch_en;
  logic [15:0]   period;
  logic          err_clr;
  logic          rdy;
  logic [DW-1:0] adata;
  logic          start, sel, vld, sch, ovr, busy;
  logic [DW-1:0] sdata;
  logic [1:0]    tmo;

  hv_adc_ctrl #(
    .ADC_DW    (DW),
    .START_CYC (START_CYC),
    .TMO_CYC   (TMO_CYC)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_adc_en            (en),
    .i_ch_en             (ch_en),
    .i_smp_period        (period),
    .i_err_clr           (err_clr),
    .i_ang_dgt_adc_rdy   (rdy),
    .i_ang_dgt_adc_data  (adata),
    .o_dgt_ang_adc_start (start),
    .o_dgt_ang_adc_sel   (sel),
    .o_smp_vld           (vld),
    .o_smp_ch            (sch),
    .o_smp_data          (sdata),
    .o_tmo_err           (tmo),
    .o_ovr_err           (ovr),
    .o_busy              (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int data;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   ch_list[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rdy_delay;   // <0: never answer, 0: random delay, >0: fixed delay
  int   exp_period;  // expected spacing of round starts, 0 = unchecked
  int   last_round = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Analog front end: each conversion answers for the channel the round order
  // predicts; ready is held for exactly three clock edges.
  initial begin : analog
    logic st_prev;
    int   d;
    int   ech;
    st_prev = 1'b0;
    rdy     = 1'b0;
    adata   = '0;
    forever begin
      @(negedge clk);
      if (start && !st_prev && !rst) begin
        if (ch_list.size() == 0) begin
          for (int c = 0; c < 2; c++) if (ch_en[c]) ch_list.push_back(c);
          if (exp_period > 0 && last_round >= 0)
            check("round_spacing", cyc - last_round, exp_period);
          last_round = cyc;
        end
        ech = (ch_list.size() > 0) ? ch_list.pop_front() : -1;
        check("start_sel", int'(sel), ech);
        if (rdy_delay >= 0) begin
          d = (rdy_delay == 0) ? int'($urandom_range(1, 30)) : rdy_delay;
          repeat (d) @(negedge clk);
          adata = DW'($urandom_range(0, (1 << DW) - 1));
          rdy   = 1'b1;
          exp_q.push_back('{ch: ech, data: int'(adata), cyc: cyc + 3});
          repeat (3) @(negedge clk);
          rdy = 1'b0;
        end
      end
      st_prev = start;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got ch %0d data %0d, expected none (cycle %0d)",
                 sch, sdata, cyc);
      end else begin
        e = exp_q.pop_front();
        check("strobe_ch", int'(sch), e.ch);
        check("strobe_data", int'(sdata), e.data);
        check("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : start_width
    int run;
    if (start) begin
      run++;
    end else if (run > 0) begin
      check("start_width", run, START_CYC);
      run = 0;
    end
  end

  task automatic idle_off();
    int k;
    k = 0;
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", int'(busy), 0);
    en = 1'b0;
    step(3);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    ch_list.delete();
    last_round = -1;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("tmo_cleared", int'(tmo), 0);
    check("ovr_cleared", int'(ovr), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, int'(start), 0);
    check({tag, "_sel"}, int'(sel), 0);
    check({tag, "_vld"}, int'(vld), 0);
    check({tag, "_ch"}, int'(sch), 0);
    check({tag, "_data"}, int'(sdata), 0);
    check({tag, "_tmo"}, int'(tmo), 0);
    check({tag, "_ovr"}, int'(ovr), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int p;
    rst        = 1'b1;
    en         = 1'b1;
    ch_en      = 2'b11;
    period     = 16'd100;
    err_clr    = 1'b0;
    rdy_delay  = -1;
    exp_period = 0;
    step(3);
    check_all_zero("reset");
    en = 1'b0;
    rst = 1'b0;
    step(2);

    // Both channels, 100-clock rounds, ready 10 clocks after each start.
    ch_en = 2'b11; period = 16'd100; rdy_delay = 10; exp_period = 100;
    en = 1'b1;
    step(350);
    idle_off();
    check("t1_ovr", int'(ovr), 0);

    // Channel 1 alone, no ready: timeout lands exactly at the end of the wait.
    ch_en = 2'b10; period = 16'd1000; rdy_delay = -1; exp_period = 0;
    en = 1'b1;
    step(START_CYC + TMO_CYC);
    check("t2_tmo_early", int'(tmo), 0);
    step(1);
    check("t2_tmo_set", int'(tmo), 2);
    idle_off();
    clear_errs();

    // Period 16 with slow conversions overruns.
    ch_en = 2'b11; period = 16'd16; rdy_delay = 20; exp_period = 0;
    en = 1'b1;
    step(200);
    check("t3_ovr", int'(ovr), 1);
    check("t3_tmo", int'(tmo), 0);
    idle_off();
    clear_errs();

    // Period below the minimum is stretched to 16.
    ch_en = 2'b01; period = 16'd5; rdy_delay = 3; exp_period = 16;
    en = 1'b1;
    step(90);
    idle_off();
    check("t4_ovr", int'(ovr), 0);

    // Randomized rounds.
    for (int r = 0; r < 4; r++) begin
      p = int'($urandom_range(120, 250));
      period = 16'(p); ch_en = 2'($urandom_range(1, 3)); rdy_delay = 0; exp_period = p;
      en = 1'b1;
      step(3 * p + 10);
      idle_off();
      check("rand_ovr", int'(ovr), 0);
      check("rand_tmo", int'(tmo), 0);
    end

    // Enable dropped after ready rises but before the strobe: round aborted.
    ch_en = 2'b01; period = 16'd1000; rdy_delay = 5; exp_period = 0;
    en = 1'b1;
    for (int k = 0; k < 100 && !rdy; k++) step(1);
    check("t5_rdy_seen", int'(rdy), 1);
    step(1);
    en = 1'b0;
    exp_q.delete();
    ch_list.delete();
    step(1);
    check("t5_busy", int'(busy), 0);
    check("t5_start", int'(start), 0);
    step(20);
    last_round = -1;

    // Timeout and error clear in the same cycle: the set wins.
    ch_en = 2'b01; period = 16'd1000; rdy_delay = -1;
    check("t6_tmo_pre", int'(tmo), 0);
    en = 1'b1;
    step(START_CYC + TMO_CYC);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t6_set_wins", int'(tmo), 1);
    step(3);
    en = 1'b0;
    step(2);
    ch_list.delete();
    last_round = -1;

    // Reset in the middle of a wait clears everything.
    ch_en = 2'b11;
    en = 1'b1;
    step(START_CYC + 5);
    check("t6_busy_pre", int'(busy), 1);
    rst = 1'b1;
    step(1);
    check_all_zero("midreset");
    en = 1'b0;
    step(1);
    rst = 1'b0;
    step(5);
    check("t6_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hv_adc_ctrl.md
HV_ADC_CTRL -- requirements
Module: hv_adc_ctrl

Interface
REQ-001 Parameter ADC_DW, default 10, ADC data width; SHALL come from the shared HV package.
REQ-002 Parameter START_CYC, default 2, start-pulse length in clocks (>=1).
REQ-003 Parameter TMO_CYC, default 255, ready-wait timeout in clocks.
REQ-004 Port i_clk  in  1  single block clock; one clock; all logic on its rising edge.
REQ-005 Port i_rst  in  1  reset, synchronous, active-high.
REQ-006 Port i_adc_en  in  1  scheduler enable.
REQ-007 Port i_ch_en  in  2  per-channel enable; bit0 = ADC1, bit1 = ADC2.
REQ-008 Port i_smp_period  in  16  round period in clocks.
REQ-009 Port i_err_clr  in  1  clear sticky errors (pulse).
REQ-010 Port i_ang_dgt_adc_rdy  in  1  analog conversion-done, asynchronous.
REQ-011 Port i_ang_dgt_adc_data  in  ADC_DW  analog result, stable while rdy high.
REQ-012 Port o_dgt_ang_adc_start  out  1  conversion start to analog.
REQ-013 Port o_dgt_ang_adc_sel  out  1  channel select to analog mux.
REQ-014 Port o_smp_vld  out  1  one-cycle result strobe.
REQ-015 Port o_smp_ch  out  1  channel of o_smp_data.
REQ-016 Port o_smp_data  out  ADC_DW  captured result, held until next o_smp_vld.
REQ-017 Port o_tmo_err  out  2  sticky per-channel timeout flags.
REQ-018 Port o_ovr_err  out  1  sticky period-overrun flag.
REQ-019 Port o_busy  out  1  high whenever FSM is not IDLE.

Function
REQ-020 Period counter SHALL run only while i_adc_en=1, count 0..P-1, and wrap, where P = max(i_smp_period, 16); a tick SHALL fire when the count equals 0.
REQ-021 While i_adc_en=0 the counter SHALL hold 0, so the first tick fires on the first enabled cycle.
REQ-022 FSM states SHALL be IDLE, START, WAIT, NEXT.
REQ-023 IDLE: on a tick with i_ch_en!=0, latch i_ch_en, select the lowest enabled channel, and go to START; a tick with i_ch_en=0 SHALL be ignored.
REQ-024 START: o_dgt_ang_adc_start=1 for exactly START_CYC cycles with o_dgt_ang_adc_sel=current channel, then go to WAIT.
REQ-025 WAIT: rdy SHALL be 2-flop synchronized and rising-edge detected.
REQ-026 On a detected edge in WAIT, capture i_ang_dgt_adc_data into o_smp_data, set o_smp_ch, pulse o_smp_vld the next cycle, and go to NEXT.
REQ-027 Latency: o_smp_vld SHALL be high in the cycle after the 3rd rising clock edge at which rdy is sampled high.
REQ-028 Timeout: if no edge is detected within TMO_CYC cycles of entering WAIT, set o_tmo_err[ch], issue no o_smp_vld, and go to NEXT.
REQ-029 NEXT (1 cycle): go to START for the remaining latched-enabled channel, else go to IDLE.
REQ-030 o_dgt_ang_adc_sel SHALL hold its value outside START/WAIT.
REQ-031 A tick arriving while not in IDLE SHALL be dropped and SHALL set o_ovr_err.
REQ-032 i_adc_en falling mid-round: the FSM goes to IDLE next cycle, start deasserts, and no o_smp_vld is issued for the aborted channel.
REQ-033 i_err_clr clears o_tmo_err and o_ovr_err; if set and clear occur in the same cycle, set SHALL win.
REQ-034 rdy edges outside WAIT SHALL be ignored.

Reset
REQ-035 While i_rst=1: FSM=IDLE, counters=0, synchronizer flops=0, and all outputs=0.
REQ-036 Reset asserted mid-round SHALL abort the round with no strobe in the following cycle.

Structure
REQ-037 ADC_DW, the FSM state enum and the minimum-period constant (16) SHALL live in the shared HV package.
REQ-038 The synchronizer plus edge detector SHALL be one sub-module, hv_adc_rdy_sync, using synchronous active-high reset.

Verification
REQ-039 Test 1: en=1, ch_en=2'b11, period=100, rdy rises 10 clks after each start -> two strobes per round, ch0 then ch1, data matches, rounds 100 clks apart.
REQ-040 Test 2: ch_en=2'b10, rdy never rises -> o_tmo_err=2'b10 after TMO_CYC+START_CYC+1 clks, no strobe; i_err_clr -> 2'b00.
REQ-041 Test 3: period=16, both channels, rdy delay 20 -> o_ovr_err=1, no round starts while busy.
REQ-042 Test 4: period=5 -> ticks every 16 clks.
REQ-043 Test 5: drop en in WAIT -> o_busy=0 next cycle, start=0, no strobe.
REQ-044 Test 6: timeout set and i_err_clr in the same cycle -> flag reads 1; reset mid-WAIT -> all outputs 0.
